pipe_reg: RTL
=============

PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits, legal range 1..128.
REQ-002 Parameter RESET_VALUE, default 0: value of out_data after reset, WIDTH bits.
REQ-003 Parameter SKID, default 1: mode select.
- 1 = two-entry skid buffer with registered in_ready.
- 0 = single-entry register with combinational in_ready.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 in_valid  input  1  upstream presents in_data.
REQ-007 in_ready  output  1  block can accept a transfer this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 flush  input  1  synchronous discard of all held entries.
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  WIDTH  head-entry payload, driven directly from a register.

Function
REQ-013 A transfer occurs on an edge where valid and ready are both 1 on the same side.
- No data is created, dropped, duplicated or reordered except by flush or rst.
REQ-014 Latency: data accepted at edge N appears on out_data with out_valid=1 in cycle N+1 when the block was empty.
REQ-015 out_data and out_valid are stable while out_valid=1 and out_ready=0.
REQ-016 SKID=1 states:
- EMPTY: no entries.
- ONE: main register holds an entry.
- TWO: main and skid registers both hold entries.
REQ-017 SKID=1 transitions:
- EMPTY to ONE on an input transfer.
- ONE to TWO on an input transfer without an output transfer.
- ONE to EMPTY on an output transfer without an input transfer.
- ONE stays ONE on simultaneous input and output transfers; main loads in_data.
- TWO to ONE on an output transfer; skid moves into main.
REQ-018 SKID=1: in_ready is a register output, 1 in EMPTY and ONE, 0 in TWO.
- In TWO, in_valid is ignored.
REQ-019 SKID=1 sustains one transfer per cycle with out_ready constantly 1.
REQ-020 SKID=0: in_ready = out_ready OR NOT out_valid (combinational).
- Single entry; one transfer per cycle sustained.
REQ-021 flush=1 at an edge empties the block.
- out_valid=0, state EMPTY, in_ready=1 in the next cycle.
- Any input transfer in the same cycle is discarded; flush has priority.
- out_data is not required to change on flush.
REQ-022 out_valid=0 whenever the block is empty; out_data is don't-care then, except after reset (REQ-024).
REQ-023 rst has priority over flush, in_valid and out_ready.

Reset
REQ-024 While rst=1 at an edge, the following hold from the next cycle:
- out_valid=0
- out_data=RESET_VALUE
- skid register=RESET_VALUE
- state EMPTY
- registered in_ready=1 (SKID=1)
REQ-025 Reset asserted mid-operation, including in TWO, discards all entries with no output transfer reported.
REQ-026 No asynchronous reset path exists; rst is sampled only on the rising clk edge.

Structure
REQ-027 State encodings (EMPTY=0, ONE=1, TWO=2) are 2-bit constants and live in the shared package mips_pkg.
REQ-028 The default data width constant is WORD_W=32 and lives in mips_pkg.
REQ-029 pipe_reg is a leaf module; no sub-module.
REQ-030 The SKID mode is selected by generate, not by runtime logic.

Verification
REQ-031 Reset: rst=1 for 2 cycles with in_valid=1, in_data=32'hDEADBEEF.
- Response: out_valid=0, out_data=0, in_ready=1 in the first cycle after release.
REQ-032 Throughput: out_ready=1, in_valid=1 with data 1,2,3...10 on consecutive cycles, both modes.
- Response: out_data=1..10 on consecutive cycles starting one cycle later, no gaps.
REQ-033 Backpressure, SKID=1: out_ready=0, then send 8'hA1, 8'hA2, 8'hA3.
- Response: A1 and A2 accepted; in_ready=0 after the second transfer; A3 held upstream.
- Then out_ready=1: output sequence A1, A2, A3, nothing lost.
REQ-034 Flush in TWO with simultaneous in_valid=1 and in_data=5.
- Response: next cycle out_valid=0 and in_ready=1; value 5 never appears on the output.
REQ-035 Reset mid-stream in TWO.
- Response: out_valid=0, out_data=RESET_VALUE; no stale entry appears after release.
REQ-036 Random valid/ready stimulus with WIDTH=8 and WIDTH=64 against a scoreboard queue.
- Response: in-order, lossless delivery; out_data stable while stalled.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline blocks.
// Holds the default datapath width and the pipe register occupancy encoding.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_reg.sv
// Valid/ready pipeline register: two-entry skid buffer with registered in_ready
// (SKID=1) or single-entry register with combinational in_ready (SKID=0).
module pipe_reg
  import mips_pkg::*;
#(
  parameter int               WIDTH       = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SKID        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (SKID) begin : g_skid
    pipe_state_e      state_p1, state_d;
    logic [WIDTH-1:0] main_p1, main_d;
    logic [WIDTH-1:0] skid_p1, skid_d;
    logic             rdy_p1;
    logic             in_fire;

    assign in_fire   = in_valid & rdy_p1;
    assign in_ready  = rdy_p1;
    assign out_valid = (state_p1 != ST_EMPTY);
    assign out_data  = main_p1;

    always_comb begin
      state_d = state_p1;
      main_d  = main_p1;
      skid_d  = skid_p1;
      case (state_p1)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_ready) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain path matters
          if (out_ready) begin
            state_d = ST_ONE;
            main_d  = skid_p1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      if (flush) state_d = ST_EMPTY;
    end

    // stage p1: occupancy, ready flag and payload registers
    always_ff @(posedge clk) begin
      if (rst) begin
        state_p1 <= ST_EMPTY;
        rdy_p1   <= 1'b1;
        main_p1  <= RESET_VALUE;
        skid_p1  <= RESET_VALUE;
      end else begin
        state_p1 <= state_d;
        rdy_p1   <= (state_d != ST_TWO);
        main_p1  <= main_d;
        skid_p1  <= skid_d;
      end
    end
  end else begin : g_single
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic             in_fire;

    assign in_ready  = out_ready | ~vld_p1;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = vld_p1;
    assign out_data  = data_p1;

    // stage p1: single entry, refilled in the same cycle it drains
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1  <= 1'b0;
        data_p1 <= RESET_VALUE;
      end else begin
        if (flush)          vld_p1 <= 1'b0;
        else if (in_fire)   vld_p1 <= 1'b1;
        else if (out_ready) vld_p1 <= 1'b0;
        if (in_fire && !flush) data_p1 <= in_data;
      end
    end
  end

endmodule
